// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one ALU between two requesters.
// Each op runs accept (IDLE) -> settle (EXEC) -> hold response (RESP) before the next grant.
module alu_share_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [CW-1:0] req0_ctr,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [CW-1:0] req1_ctr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_zero,
    output logic          rsp_overflow,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [CW-1:0] alu_ctr,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    input  logic          alu_ari
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [CW-1:0] r_op_ctr;
    logic          r_op_id;
    logic          r_last_grant;

    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_result;
    logic          r_rsp_zero;
    logic          r_rsp_ovf;

    logic          w_grant_id;
    logic          w_xfer;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == S_IDLE) begin
            req0_ready = req0_valid & ~w_grant_id;
            req1_ready = req1_valid &  w_grant_id;
        end
        w_xfer = req0_ready | req1_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer)    w_state_nxt = S_EXEC;
            S_EXEC:                 w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctr     <= '0;
            r_op_id      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_op_a       <= w_grant_id ? req1_a   : req0_a;
                r_op_b       <= w_grant_id ? req1_b   : req0_b;
                r_op_ctr     <= w_grant_id ? req1_ctr : req0_ctr;
                r_op_id      <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            // ALU outputs have had the whole EXEC cycle to settle from the op registers.
            if (r_state == S_EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_op_id;
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
                r_rsp_ovf    <= alu_overflow & alu_ari;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign alu_a        = r_op_a;
    assign alu_b        = r_op_b;
    assign alu_ctr      = r_op_ctr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_ovf;

endmodule
